// File: rtl/sd_iosync_p_buf.sv
// Receive-clock half of a four-phase req/ack clock-domain crossing. Incoming words land in an
// elastic buffer, so the sender keeps handshaking while the downstream srdy/drdy port stalls.
module sd_iosync_p_buf #(
    parameter int width       = 8,
    parameter int depth       = 4,
    parameter int sync_stages = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_req,
    output logic                      s_ack,
    input  logic [width-1:0]          s_data,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [width-1:0]          p_data,
    output logic [$clog2(depth):0]    p_usage
);

    localparam int asz          = $clog2(depth);
    localparam int send_ack_bit = 1;

    typedef enum logic [1:0] {
        WAIT_REQ = 2'b01,
        SEND_ACK = 2'b10
    } state_t;

    logic [sync_stages-1:0] hgff_sync_q;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic [asz:0]           wr_ptr_q, wr_ptr_d;
    logic [asz:0]           rd_ptr_q, rd_ptr_d;
    logic [width-1:0]       mem [depth];
    logic                   load;
    logic                   pop;
    logic                   empty;
    logic                   full;

    // s_req is asynchronous to clk; only the last stage of the chain may feed logic.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hgff_sync_q <= '0;
        end else begin
            hgff_sync_q <= {hgff_sync_q[sync_stages-2:0], s_req};
        end
    end

    assign req_s = hgff_sync_q[sync_stages-1];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[asz-1:0] == rd_ptr_q[asz-1:0]) &&
                   (wr_ptr_q[asz] != rd_ptr_q[asz]);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            WAIT_REQ: begin
                if (req_s && !full) begin
                    load    = 1'b1;
                    state_d = SEND_ACK;
                end
            end
            SEND_ACK: begin
                if (!req_s) begin
                    state_d = WAIT_REQ;
                end
            end
            default: state_d = WAIT_REQ;
        endcase
    end

    assign pop      = !empty && p_drdy;
    assign wr_ptr_d = wr_ptr_q + (asz+1)'(load);
    assign rd_ptr_d = rd_ptr_q + (asz+1)'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= WAIT_REQ;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the buffer RAM is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (load) begin
            mem[wr_ptr_q[asz-1:0]] <= s_data;
        end
    end

    // s_ack comes straight from a state flop so the sending domain never sees a glitch.
    assign s_ack   = state_q[send_ack_bit];
    assign p_srdy  = !empty;
    assign p_data  = mem[rd_ptr_q[asz-1:0]];
    assign p_usage = wr_ptr_q - rd_ptr_q;

endmodule
